// File: rtl/invader_pkg.sv
// Shared types and widths for the invader march sequencer.
package invader_pkg;

  localparam int ALIVE_W     = 6;
  localparam int LEVEL_W     = 2;
  localparam int FRAME_CNT_W = 8;

  // Game-level flow of the marching fleet.
  typedef enum logic [2:0] {
    IDLE,
    COUNTDOWN,
    MARCH,
    DESCEND,
    WAVE_CLEAR,
    GAME_OVER
  } march_st_t;

  // True in the states where the fleet is on the move and kills count.
  function automatic logic isPlaying(input march_st_t st);
    return (st == MARCH) || (st == DESCEND);
  endfunction

endpackage

// File: rtl/sof_down_counter.sv
// Loadable frame counter shared by the start countdown and the descent.
// Decrements once per startOfFrame while running; 'expire' flags the frame
// pulse that takes it from 1 to 0, 'done' is the registered form of that
// event, qualified by pulseEn so the owner can suppress it.
module sof_down_counter
  import invader_pkg::*;
(
  input  logic                   clk,
  input  logic                   resetN,
  input  logic                   load,
  input  logic [FRAME_CNT_W-1:0] loadValue,
  input  logic                   startOfFrame,
  input  logic                   run,
  input  logic                   pulseEn,
  output logic                   expire,
  output logic                   done
);

  logic [FRAME_CNT_W-1:0] count;

  assign expire = run && startOfFrame && (count == FRAME_CNT_W'(1));

  // Frame count: load wins, otherwise step down on each frame until zero.
  // NOTE: state is written with <= so every flop samples pre-edge values;
  // blocking = here would make results depend on block evaluation order.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      count <= '0;
    end else if (load) begin
      count <= loadValue;
    end else if (run && startOfFrame && (count != '0)) begin
      count <= count - FRAME_CNT_W'(1);
    end
  end

  // One-cycle pulse in the cycle after the frame that reached zero.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      done <= 1'b0;
    end else begin
      done <= expire && pulseEn && !load;
    end
  end

endmodule

// File: rtl/invader_march_ctrl.sv
// Game-flow sequencer for the invader fleet: countdown, march, descend,
// wave clear and game over. Produces the fleet mover controls, the fleet
// position hold, the speed level and the alive count. All outputs are flops.
module invader_march_ctrl
  import invader_pkg::*;
#(
  parameter int NUM_INVADERS       = 32,
  parameter int START_DELAY_FRAMES = 60,
  parameter int DESCEND_FRAMES     = 30,
  parameter int SPEED_STEP         = 8,
  parameter int MAX_LEVEL          = 3
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic               startGame,
  input  logic               invaderHit,
  input  logic               borderHit,
  input  logic               fleetLanded,
  output logic               idleN,
  output logic               chgDir,
  output logic               oneSec,
  output logic               fleetResetN,
  output logic [LEVEL_W-1:0] speedLevel,
  output logic [ALIVE_W-1:0] aliveCount,
  output logic               waveClear,
  output logic               gameOver
);

  localparam logic [ALIVE_W-1:0]     ALIVE_INIT   = ALIVE_W'(NUM_INVADERS);
  localparam logic [ALIVE_W-1:0]     KILL_WRAP    = ALIVE_W'(SPEED_STEP - 1);
  localparam logic [LEVEL_W-1:0]     LEVEL_TOP    = LEVEL_W'(MAX_LEVEL);
  localparam logic [FRAME_CNT_W-1:0] START_LOAD   = FRAME_CNT_W'(START_DELAY_FRAMES);
  localparam logic [FRAME_CNT_W-1:0] DESCEND_LOAD = FRAME_CNT_W'(DESCEND_FRAMES);

  march_st_t              state;
  march_st_t              nextState;
  logic                   borderPrev;
  logic                   borderRise;
  logic                   hitValid;
  logic                   lastKill;
  logic                   cntLoad;
  logic [FRAME_CNT_W-1:0] cntLoadValue;
  logic                   cntRun;
  logic                   cntPulseEn;
  logic                   cntExpire;
  logic [ALIVE_W-1:0]     killCnt;

  // A landing fleet swallows any kill in the same cycle.
  assign borderRise = borderHit && !borderPrev;
  assign hitValid   = isPlaying(state) && invaderHit && !fleetLanded;
  assign lastKill   = hitValid && (aliveCount == ALIVE_W'(1));

  // The frame counter runs in both timed states; only descents emit oneSec,
  // and not when a landing or the last kill pre-empts the descent end.
  assign cntRun     = (state == COUNTDOWN) || (state == DESCEND);
  assign cntPulseEn = (state == DESCEND) && !fleetLanded && !lastKill;

  sof_down_counter u_frameCnt (
    .clk          (clk),
    .resetN       (resetN),
    .load         (cntLoad),
    .loadValue    (cntLoadValue),
    .startOfFrame (startOfFrame),
    .run          (cntRun),
    .pulseEn      (cntPulseEn),
    .expire       (cntExpire),
    .done         (oneSec)
  );

  // State register.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state and counter-load decode; landing > last kill > border/descent end.
  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    nextState    = state;
    cntLoad      = 1'b0;
    cntLoadValue = START_LOAD;
    case (state)
      IDLE: begin
        if (startGame) begin
          nextState = COUNTDOWN;
          cntLoad   = 1'b1;
        end
      end
      COUNTDOWN: begin
        if (cntExpire) nextState = MARCH;
      end
      MARCH: begin
        if (fleetLanded) begin
          nextState = GAME_OVER;
        end else if (lastKill) begin
          nextState = WAVE_CLEAR;
        end else if (borderRise) begin
          nextState    = DESCEND;
          cntLoad      = 1'b1;
          cntLoadValue = DESCEND_LOAD;
        end
      end
      DESCEND: begin
        if (fleetLanded) begin
          nextState = GAME_OVER;
        end else if (lastKill) begin
          nextState = WAVE_CLEAR;
        end else if (cntExpire) begin
          nextState = MARCH;
        end
      end
      WAVE_CLEAR: begin
        nextState = COUNTDOWN;
        cntLoad   = 1'b1;
      end
      GAME_OVER: begin
        if (!startGame) nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  // Alive count, kill counter and speed level; reloaded on game start and wave clear.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      aliveCount <= ALIVE_INIT;
      killCnt    <= '0;
      speedLevel <= '0;
    end else if (((state == IDLE) && startGame) || (state == WAVE_CLEAR)) begin
      aliveCount <= ALIVE_INIT;
      killCnt    <= '0;
      speedLevel <= '0;
    end else if (hitValid) begin
      if (aliveCount != '0) aliveCount <= aliveCount - ALIVE_W'(1);
      if (killCnt == KILL_WRAP) begin
        killCnt <= '0;
        if (speedLevel != LEVEL_TOP) speedLevel <= speedLevel + LEVEL_W'(1);
      end else begin
        killCnt <= killCnt + ALIVE_W'(1);
      end
    end
  end

  // Registered control outputs, decoded from the state being entered.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      borderPrev  <= 1'b0;
      idleN       <= 1'b0;
      chgDir      <= 1'b0;
      fleetResetN <= 1'b0;
      waveClear   <= 1'b0;
      gameOver    <= 1'b0;
    end else begin
      borderPrev  <= borderHit;
      idleN       <= isPlaying(nextState);
      chgDir      <= (state == MARCH) && (nextState == DESCEND);
      fleetResetN <= !((nextState == IDLE) || (nextState == WAVE_CLEAR) ||
                       (nextState == GAME_OVER));
      waveClear   <= (nextState == WAVE_CLEAR);
      gameOver    <= (nextState == GAME_OVER);
    end
  end

endmodule

// File: tb/tb_invader_march_ctrl.sv
// Directed bench for invader_march_ctrl with hand-computed expectations.
module tb_invader_march_ctrl;

  logic       clk;
  logic       resetN;
  logic       startOfFrame;
  logic       startGame;
  logic       invaderHit;
  logic       borderHit;
  logic       fleetLanded;
  logic       idleN;
  logic       chgDir;
  logic       oneSec;
  logic       fleetResetN;
  logic [1:0] speedLevel;
  logic [5:0] aliveCount;
  logic       waveClear;
  logic       gameOver;

  int errors = 0;
  int checks = 0;
  int chgDirSeen = 0;
  int oneSecSeen = 0;
  int waveClearSeen = 0;

  invader_march_ctrl #(
    .NUM_INVADERS       (32),
    .START_DELAY_FRAMES (60),
    .DESCEND_FRAMES     (30),
    .SPEED_STEP         (8),
    .MAX_LEVEL          (3)
  ) dut (
    .clk          (clk),
    .resetN       (resetN),
    .startOfFrame (startOfFrame),
    .startGame    (startGame),
    .invaderHit   (invaderHit),
    .borderHit    (borderHit),
    .fleetLanded  (fleetLanded),
    .idleN        (idleN),
    .chgDir       (chgDir),
    .oneSec       (oneSec),
    .fleetResetN  (fleetResetN),
    .speedLevel   (speedLevel),
    .aliveCount   (aliveCount),
    .waveClear    (waveClear),
    .gameOver     (gameOver)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    chgDirSeen    += int'(chgDir);
    oneSecSeen    += int'(oneSec);
    waveClearSeen += int'(waveClear);
  endtask

  // One frame: a startOfFrame cycle followed by two quiet cycles.
  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      startOfFrame = 1'b1;
      step();
      startOfFrame = 1'b0;
      step();
      step();
    end
  endtask

  // Kill pulses, one cycle high and one low each.
  task automatic hits(input int n);
    for (int i = 0; i < n; i++) begin
      invaderHit = 1'b1;
      step();
      invaderHit = 1'b0;
      step();
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    check({tag, "_idleN"}, idleN, 0);
    check({tag, "_chgDir"}, chgDir, 0);
    check({tag, "_oneSec"}, oneSec, 0);
    check({tag, "_fleetResetN"}, fleetResetN, 0);
    check({tag, "_speedLevel"}, speedLevel, 0);
    check({tag, "_aliveCount"}, aliveCount, 32);
    check({tag, "_waveClear"}, waveClear, 0);
    check({tag, "_gameOver"}, gameOver, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected end of run");
    $fatal(1, "watchdog expired");
  end

  initial begin
    resetN       = 1'b0;
    startOfFrame = 1'b0;
    startGame    = 1'b0;
    invaderHit   = 1'b0;
    borderHit    = 1'b0;
    fleetLanded  = 1'b0;
    step();
    step();
    checkResetOutputs("reset");

    // Start countdown: hold released next cycle, march after frame 60.
    resetN = 1'b1;
    step();
    startGame = 1'b1;
    step();
    check("start_fleetResetN", fleetResetN, 1);
    check("start_idleN", idleN, 0);
    hits(1);
    check("countdown_hit_ignored", aliveCount, 32);
    frames(59);
    check("countdown59_idleN", idleN, 0);
    frames(1);
    check("countdown60_idleN", idleN, 1);

    // Border held high: one chgDir, oneSec after the 30th frame, no retrigger.
    chgDirSeen = 0;
    oneSecSeen = 0;
    borderHit = 1'b1;
    step();
    check("chgDir_first", chgDir, 1);
    step();
    check("chgDir_one_cycle", chgDir, 0);
    frames(29);
    check("descend29_oneSec_count", oneSecSeen, 0);
    check("descend_chgDir_count", chgDirSeen, 1);
    startOfFrame = 1'b1;
    step();
    startOfFrame = 1'b0;
    check("descend30_oneSec", oneSec, 1);
    step();
    check("oneSec_one_cycle", oneSec, 0);
    frames(3);
    check("border_held_no_retrigger", chgDirSeen, 1);
    check("march_idleN", idleN, 1);

    // New rising edge starts a second descent; kills counted during it.
    borderHit = 1'b0;
    step();
    borderHit = 1'b1;
    step();
    check("chgDir_rearm", chgDir, 1);
    hits(1);
    check("kill1_alive", aliveCount, 31);
    hits(6);
    check("kill7_alive", aliveCount, 25);
    check("kill7_level", speedLevel, 0);
    // Eighth kill lands on a frame pulse: both must be processed.
    invaderHit   = 1'b1;
    startOfFrame = 1'b1;
    step();
    invaderHit   = 1'b0;
    startOfFrame = 1'b0;
    check("kill8_alive", aliveCount, 24);
    check("kill8_level", speedLevel, 1);
    step();
    hits(16);
    check("kill24_alive", aliveCount, 8);
    check("kill24_level", speedLevel, 3);
    frames(29);
    check("descend2_oneSec_count", oneSecSeen, 2);
    hits(7);
    check("kill31_alive", aliveCount, 1);
    check("kill31_level", speedLevel, 3);

    // Last kill together with a border rising edge: wave clear wins.
    borderHit = 1'b0;
    step();
    borderHit  = 1'b1;
    invaderHit = 1'b1;
    step();
    invaderHit = 1'b0;
    check("wave_waveClear", waveClear, 1);
    check("wave_chgDir", chgDir, 0);
    check("wave_alive_zero", aliveCount, 0);
    check("wave_level_saturated", speedLevel, 3);
    check("wave_fleetResetN", fleetResetN, 0);
    check("wave_idleN", idleN, 0);
    step();
    check("wave_pulse_one_cycle", waveClear, 0);
    check("wave_alive_reload", aliveCount, 32);
    check("wave_level_cleared", speedLevel, 0);
    check("wave_countdown_fleetResetN", fleetResetN, 1);
    frames(59);
    check("wave_countdown59_idleN", idleN, 0);
    frames(1);
    check("wave_countdown60_idleN", idleN, 1);
    check("wave_no_chgDir", chgDirSeen, 2);
    check("wave_pulse_count", waveClearSeen, 1);

    // Landing with a simultaneous kill: game over, kill discarded.
    hits(1);
    check("pre_land_alive", aliveCount, 31);
    fleetLanded = 1'b1;
    invaderHit  = 1'b1;
    step();
    fleetLanded = 1'b0;
    invaderHit  = 1'b0;
    check("land_gameOver", gameOver, 1);
    check("land_idleN", idleN, 0);
    check("land_fleetResetN", fleetResetN, 0);
    check("land_alive", aliveCount, 31);
    step();
    check("land_hold_gameOver", gameOver, 1);
    startGame = 1'b0;
    step();
    check("idle_gameOver", gameOver, 0);
    check("idle_fleetResetN", fleetResetN, 0);

    // Reset in the middle of a descent: no oneSec afterwards, back to idle.
    startGame = 1'b1;
    step();
    check("restart_fleetResetN", fleetResetN, 1);
    check("restart_alive", aliveCount, 32);
    frames(60);
    check("restart_idleN", idleN, 1);
    borderHit = 1'b0;
    step();
    borderHit = 1'b1;
    step();
    check("restart_chgDir", chgDir, 1);
    frames(5);
    hits(1);
    check("restart_kill_alive", aliveCount, 31);
    oneSecSeen = 0;
    resetN = 1'b0;
    #1;
    checkResetOutputs("midreset");
    startGame = 1'b0;
    borderHit = 1'b0;
    step();
    step();
    resetN = 1'b1;
    frames(30);
    check("midreset_no_oneSec", oneSecSeen, 0);
    check("midreset_idleN", idleN, 0);
    check("midreset_fleetResetN", fleetResetN, 0);
    startGame = 1'b1;
    step();
    check("midreset_idle_start", fleetResetN, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/invader_march_ctrl.md
# invader_march_ctrl

Sequencer for the invader fleet's marching datapath. It owns the game-level flow: start countdown, march, descend, wave clear and game over. It generates the `idleN`, `chgDir` and `oneSec` controls consumed by the fleet mover, a per-fleet active-low position reset, and a speed level that the top level maps to the fleet step size. It sits between the collision/hit logic and the fleet mover, and all its timing is in frames (`startOfFrame` pulses).

## Interface
Parameters:
- `NUM_INVADERS`, 32: invaders per wave (1..63).
- `START_DELAY_FRAMES`, 60: frames of countdown before marching.
- `DESCEND_FRAMES`, 30: frames spent descending per border hit.
- `SPEED_STEP`, 8: kills per speed-level increment.
- `MAX_LEVEL`, 3: saturation value of `speedLevel`.

Ports:
- `clk` in 1: system clock.
- `resetN` in 1: asynchronous, active-low reset.
- `startOfFrame` in 1: one-cycle pulse per frame.
- `startGame` in 1: level; high requests play.
- `invaderHit` in 1: one-cycle pulse per invader destroyed.
- `borderHit` in 1: level; some invader pixel touches a side border.
- `fleetLanded` in 1: one-cycle pulse; the fleet reached the player row.
- `idleN` out 1: high while the fleet should move.
- `chgDir` out 1: one-cycle pulse that starts a descent.
- `oneSec` out 1: one-cycle pulse that ends a descent.
- `fleetResetN` out 1: active-low hold of the fleet position; the top level ANDs it with `resetN`.
- `speedLevel` out 2: 0..`MAX_LEVEL`.
- `aliveCount` out 6: invaders remaining.
- `waveClear` out 1: one-cycle pulse when a wave is cleared.
- `gameOver` out 1: level.

## Operation
States: IDLE, COUNTDOWN, MARCH, DESCEND, WAVE_CLEAR, GAME_OVER.

- **IDLE**
  - `fleetResetN`=0, `idleN`=0.
  - When `startGame`=1: load `aliveCount`=`NUM_INVADERS`, clear the kill counter and level, load the frame counter with `START_DELAY_FRAMES`, go to COUNTDOWN.
- **COUNTDOWN**
  - `fleetResetN`=1, `idleN`=0.
  - The frame counter decrements on each `startOfFrame`. On the pulse where it reads 1 it reaches 0, and the state goes to MARCH.
- **MARCH**
  - `idleN`=1.
  - A `borderHit` rising edge (current=1, registered previous=0) pulses `chgDir`, loads `DESCEND_FRAMES`, and goes to DESCEND.
- **DESCEND**
  - `idleN`=1.
  - Frame countdown as in COUNTDOWN. At 0, pulse `oneSec` and go to MARCH.
  - `borderHit` edges are ignored.
  - The fleet still touching the border on return does not retrigger, because only rising edges count.
- **Kill handling (MARCH and DESCEND)**
  - Each `invaderHit` decrements `aliveCount`, saturating at 0.
  - The kill counter counts 0..`SPEED_STEP`-1 and wraps. On each wrap `speedLevel` increments, saturating at `MAX_LEVEL`.
  - When `aliveCount` goes 1→0, go to WAVE_CLEAR.
- **WAVE_CLEAR** (one cycle)
  - `waveClear`=1, `fleetResetN`=0.
  - Reload `aliveCount`; clear the kill counter and `speedLevel`.
  - Load `START_DELAY_FRAMES` and go to COUNTDOWN.
- **GAME_OVER**
  - Entered from MARCH/DESCEND on `fleetLanded`.
  - `gameOver`=1, `idleN`=0, `fleetResetN`=0.
  - Go to IDLE when `startGame`=0.
- **Priorities within one cycle:** `fleetLanded` > last kill (→WAVE_CLEAR) > `borderHit` edge / descent end. Ordinary kills are always counted alongside `chgDir` or `oneSec`.
- **Mid-operation reset:** `resetN` low in any state returns to IDLE with all outputs at reset values. No partial pulses are emitted.

## Timing
- All outputs are registered.
- Reset values: `idleN`=0, `chgDir`=0, `oneSec`=0, `fleetResetN`=0, `speedLevel`=0, `aliveCount`=`NUM_INVADERS`, `waveClear`=0, `gameOver`=0.
- `chgDir` is high exactly one cycle, in cycle N+1, where N is the first cycle with `borderHit`=1 and previous=0.
- `oneSec` is high exactly one cycle, the cycle after the `startOfFrame` that drives the descend counter to 0. The descent therefore lasts `DESCEND_FRAMES` frames.
- `invaderHit` updates `aliveCount` and `speedLevel` one cycle later. `invaderHit` is ignored outside MARCH/DESCEND.
- `startOfFrame` and `invaderHit` in the same cycle are both processed.

## Structure
- **Package `invader_pkg`:**
  - state enum `march_st_t`;
  - `ALIVE_W`=6, `LEVEL_W`=2;
  - frame-counter width `FRAME_CNT_W`=8.
- **Sub-module `sof_down_counter`:**
  - loadable down counter that decrements on `startOfFrame`;
  - outputs a registered `done` pulse at 0;
  - shared by COUNTDOWN and DESCEND.

## Test plan
1. Reset, `startGame`=1 → `fleetResetN` rises the next cycle; `idleN` rises after the 60th `startOfFrame`.
2. In MARCH, hold `borderHit` high for 10 frames → exactly one `chgDir` pulse; `oneSec` one cycle after the 30th subsequent frame pulse; no second `chgDir` while `borderHit` is still high.
3. 8 `invaderHit` pulses → `aliveCount`=24, `speedLevel`=1. After 24 kills, `speedLevel`=3 and stays 3 on further kills.
4. The 32nd kill in the same cycle as a `borderHit` rising edge → `waveClear` pulse, no `chgDir`, `aliveCount`=32, `speedLevel`=0, COUNTDOWN restarts.
5. `fleetLanded` with `invaderHit` in the same cycle → `gameOver`=1, `idleN`=0, `aliveCount` unchanged. `startGame`=0 → IDLE.
6. `resetN` pulsed mid-DESCEND → no `oneSec`; all outputs at reset values; state IDLE.
